// File: rtl/mips_pkg.sv
// Shared CPU definitions: boot loader states and word/byte addressing constants.
package mips_pkg;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

    localparam int BYTES_PER_WORD   = 4;
    localparam int WORD_BYTES_SHIFT = 2;
    localparam int LANE_W           = 2;

    // Byte address of word 'idx' counted from 'base' (same <<2 as the PC path).
    function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                   input logic [31:0] idx);
        return base + (idx << WORD_BYTES_SHIFT);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a length-prefixed, checksummed
// byte frame, packs big-endian words, writes them to the instruction memory and
// holds the CPU in reset until a frame has been fully loaded and verified.
module imem_loader
    import mips_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        restart,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int          IDX_W    = ADDR_WIDTH + 1;
    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

    loader_state_t     r_state;
    loader_state_t     w_next;

    logic [7:0]        r_len_hi;
    logic [7:0]        r_sum;
    logic [LANE_W-1:0] r_lane;
    logic [23:0]       r_asm;
    logic [IDX_W-1:0]  r_widx;
    logic [IDX_W-1:0]  r_nwords;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;

    logic              w_accepting;
    logic              w_xfer;
    logic [31:0]       w_len;
    logic              w_len_bad;
    logic              w_word_end;
    logic              w_last_word;
    logic [31:0]       w_word_addr;

    assign w_accepting = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                         (r_state == DATA)   || (r_state == CSUM);
    // A restart pulse blocks the concurrent byte so it is never half-consumed.
    assign rx_ready    = w_accepting && !restart;
    assign w_xfer      = rx_valid && rx_ready;

    assign w_len       = {16'd0, r_len_hi, rx_data};
    assign w_len_bad   = w_len > CAPACITY;
    assign w_word_end  = (r_lane == LANE_W'(BYTES_PER_WORD - 1));
    assign w_last_word = ((r_widx + IDX_W'(1)) == r_nwords);
    assign w_word_addr = word_byte_addr(BASE_ADDR, 32'(r_widx));

    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= LEN_HI;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        w_next   = r_state;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b1;
        case (r_state)
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ERROR:   error = 1'b1;
            default: ;
        endcase
        if (restart) begin
            w_next = LEN_HI;
        end else if (w_xfer) begin
            case (r_state)
                LEN_HI: w_next = LEN_LO;
                LEN_LO: begin
                    if (w_len_bad) begin
                        w_next = ERROR;
                    end else if (w_len == 32'd0) begin
                        w_next = CSUM;
                    end else begin
                        w_next = DATA;
                    end
                end
                DATA: begin
                    if (w_word_end && w_last_word) begin
                        w_next = CSUM;
                    end
                end
                CSUM:    w_next = (rx_data == r_sum) ? DONE : ERROR;
                default: ;
            endcase
        end
    end

    // Length capture, checksum accumulation, word assembly and write strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_len_hi <= 8'd0;
            r_sum    <= 8'd0;
            r_lane   <= '0;
            r_asm    <= 24'd0;
            r_widx   <= '0;
            r_nwords <= '0;
            r_we     <= 1'b0;
            r_addr   <= BASE_ADDR;
            r_wdata  <= 32'd0;
        end else begin
            r_we <= 1'b0;
            if (restart) begin
                r_lane <= '0;
                r_widx <= '0;
                r_sum  <= 8'd0;
            end else if (w_xfer) begin
                if (r_state != CSUM) begin
                    r_sum <= r_sum + rx_data;
                end
                case (r_state)
                    LEN_HI: r_len_hi <= rx_data;
                    LEN_LO: r_nwords <= w_len[IDX_W-1:0];
                    DATA: begin
                        r_lane <= r_lane + LANE_W'(1);
                        if (w_word_end) begin
                            r_we    <= 1'b1;
                            r_wdata <= {r_asm, rx_data};
                            r_addr  <= w_word_addr;
                            r_widx  <= r_widx + IDX_W'(1);
                        end else begin
                            r_asm <= {r_asm[15:0], rx_data};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a frame-position reference model.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int          AW   = 8;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          CAP  = 1 << AW;

    logic        clock;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        restart;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .restart  (restart),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  frame_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks position in the frame, not the design's states.
    int          m_pos;
    int          m_n;
    int          m_status;   // 0 loading, 1 done, 2 rejected
    logic [7:0]  m_hi;
    logic [7:0]  m_sum;
    logic [31:0] m_word;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_data;

    task automatic model_reset();
        m_pos = 0; m_n = 0; m_status = 0; m_hi = 8'd0; m_sum = 8'd0;
        m_word = 32'd0; m_we = 1'b0; m_addr = BASE; m_data = 32'd0;
    endtask

    task automatic model_step();
        m_we = 1'b0;
        if (restart) begin
            m_pos = 0; m_sum = 8'd0; m_status = 0;
        end else if (rx_valid && m_status == 0) begin
            if (m_pos == 0) begin
                m_hi = rx_data;
            end else if (m_pos == 1) begin
                m_n = int'({m_hi, rx_data});
                if (m_n > CAP) m_status = 2;
            end else if (m_pos < 2 + 4 * m_n) begin
                m_word = {m_word[23:0], rx_data};
                if ((m_pos - 2) % 4 == 3) begin
                    m_we   = 1'b1;
                    m_addr = BASE + 32'(4 * ((m_pos - 2) / 4));
                    m_data = m_word;
                end
            end else begin
                m_status = (rx_data == m_sum) ? 1 : 2;
            end
            m_sum = m_sum + rx_data;
            m_pos++;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (cmp_en) begin
                chk("rx_ready", rx_ready, (m_status == 0) && !restart);
                chk("mem_we", mem_we, m_we);
                if (m_we) begin
                    chk("mem_addr", mem_addr, m_addr);
                    chk("mem_wdata", mem_wdata, m_data);
                end
                chk("done", done, m_status == 1);
                chk("error", error, m_status == 2);
                chk("cpu_hold", cpu_hold, m_status != 1);
                if (mem_we) begin
                    wr_addr_q.push_back(mem_addr);
                    wr_data_q.push_back(mem_wdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        bit acc   = 1'b0;
        int guard = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!acc && guard < 20) begin
            @(negedge clock);
            acc = rx_ready;
            @(posedge clock);
            #1;
            guard++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_accept: byte %h not accepted within 20 cycles", b);
        end
    endtask

    task automatic send_frame(input int count, input bit toggle);
        for (int i = 0; i < count; i++) begin
            send_byte(frame_q[i]);
            if (toggle) begin
                rx_valid = 1'b0;
                @(posedge clock);
                #1;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clock);
        #1;
        restart = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic load_good();
        frame_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                    8'hAC, 8'h08, 8'h00, 8'h00, 8'hE3};
    endtask

    task automatic check_two_writes(input string tag);
        chk({tag, "_nwrites"}, wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            chk({tag, "_addr0"}, wr_addr_q[0], 32'h0000_0000);
            chk({tag, "_data0"}, wr_data_q[0], 32'h2008_0005);
            chk({tag, "_addr1"}, wr_addr_q[1], 32'h0000_0004);
            chk({tag, "_data1"}, wr_data_q[1], 32'hAC08_0000);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        restart  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, BASE);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_hold", cpu_hold, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rst_rx_ready", rx_ready, 1'b1);
        cmp_en = 1'b1;

        // Two-word frame, continuous stream.
        load_good();
        send_frame(11, 1'b0);
        chk("t1_done_now", done, 1'b1);
        chk("t1_hold_now", cpu_hold, 1'b0);
        idle(2);
        check_two_writes("t1");
        chk("t1_ready_after", rx_ready, 1'b0);

        // Same frame with rx_valid toggling every cycle.
        pulse_restart();
        chk("t2_hold_restart", cpu_hold, 1'b1);
        send_frame(11, 1'b1);
        idle(2);
        check_two_writes("t2");
        chk("t2_done", done, 1'b1);

        // Empty frame.
        pulse_restart();
        frame_q = '{8'h00, 8'h00, 8'h00};
        send_frame(3, 1'b0);
        idle(2);
        chk("t3_nwrites", wr_addr_q.size(), 0);
        chk("t3_done", done, 1'b1);

        // Bad checksum.
        pulse_restart();
        load_good();
        frame_q[10] = 8'hE4;
        send_frame(11, 1'b0);
        idle(2);
        check_two_writes("t4");
        chk("t4_error", error, 1'b1);
        chk("t4_done", done, 1'b0);
        chk("t4_hold", cpu_hold, 1'b1);

        // Oversize length 0x0101 > 256 words.
        pulse_restart();
        frame_q = '{8'h01, 8'h01};
        send_frame(2, 1'b0);
        chk("t5_error_now", error, 1'b1);
        idle(2);
        chk("t5_ready", rx_ready, 1'b0);
        chk("t5_nwrites", wr_addr_q.size(), 0);

        // Restart after 6 bytes with a byte offered in the same cycle.
        pulse_restart();
        load_good();
        for (int i = 0; i < 6; i++) send_byte(frame_q[i]);
        restart = 1'b1;
        rx_data = frame_q[6];
        #1;
        chk("t6_ready_restart", rx_ready, 1'b0);
        @(posedge clock);
        #1;
        restart  = 1'b0;
        rx_valid = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        idle(1);
        send_frame(11, 1'b0);
        idle(2);
        check_two_writes("t6");
        chk("t6_done", done, 1'b1);

        // Asynchronous reset after 5 bytes.
        pulse_restart();
        for (int i = 0; i < 5; i++) send_byte(frame_q[i]);
        rx_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t7_hold", cpu_hold, 1'b1);
        chk("t7_we", mem_we, 1'b0);
        chk("t7_addr", mem_addr, BASE);
        chk("t7_done", done, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
        idle(1);
        send_frame(11, 1'b0);
        idle(2);
        check_two_writes("t7");
        chk("t7_done_end", done, 1'b1);
        chk("t7_hold_end", cpu_hold, 1'b0);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
